// File: rtl/pkt_pkg.sv
// Shared packet-stage definitions: filter FSM encoding, byte positions and
// the byte-XOR helper used for frame checksums.
package pkt_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPass = 2'd1,
        StDrop = 2'd2
    } state_e;

    // Message ID lives in byte0 of the first word of a frame.
    localparam int unsigned IdByte = 0;
    // Transmitted checksum lives in byte0 of the last word of a frame.
    localparam int unsigned CsumByte = 0;

    // XOR of the four bytes of a word, optionally leaving out the checksum byte.
    function automatic logic [7:0] xor_bytes(input logic [31:0] word, input logic skip_csum);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            if (!(skip_csum && (i == int'(CsumByte)))) begin
                acc = acc ^ word[i*8 +: 8];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Output register plus one-entry skid buffer for a 32-bit AXI-Stream word with
// tlast/tuser. Upstream ready is registered and reflects an empty skid slot.
module axis_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        in_user,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        out_user,
    output logic        out_valid,
    input  logic        out_ready
);

    // Entries are packed as {user, last, data}.
    logic [33:0] out_q, out_d;
    logic [33:0] skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        skid_full_q, skid_full_d;
    logic        ready_q;
    logic        in_fire;
    logic        out_fire;

    assign in_fire  = in_valid & ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state: refill the output register from the skid slot first, else from input.
    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;
        if (skid_full_q) begin
            if (out_fire) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!out_valid_q || out_fire) begin
                out_d       = {in_user, in_last, in_data};
                out_valid_d = 1'b1;
            end else begin
                // Output stalled: park the word that was already in flight.
                skid_d      = {in_user, in_last, in_data};
                skid_full_d = 1'b1;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; ready is held low through reset and rises one clock after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            ready_q     <= !skid_full_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_data  = out_q[31:0];
    assign out_last  = out_q[32];
    assign out_user  = out_q[33];
    assign out_valid = out_valid_q;

endmodule

// File: rtl/frame_filter.sv
// Frame filter: selects frames by the message ID in byte0 of the first word,
// checks the per-frame XOR checksum, and keeps saturating frame statistics.
module frame_filter
    import pkt_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    input  logic             m_axis_tready,
    input  logic             cfg_en,
    input  logic [7:0]       cfg_id,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_pass,
    output logic [CNT_W-1:0] stat_drop,
    output logic [CNT_W-1:0] stat_err
);

    state_e           state_q, state_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       csum_base;
    logic [7:0]       csum_calc;
    logic [CNT_W-1:0] pass_q, drop_q, err_q;
    logic             in_fire;
    logic             pass_sel;
    logic             fwd_user;
    logic             last_fire;
    logic             pass_inc, drop_inc, err_inc;

    assign in_fire   = s_axis_tvalid & s_axis_tready;
    assign last_fire = in_fire & s_axis_tlast;

    // FSM next-state; cfg is only looked at while waiting for a first word.
    always_comb begin
        state_d  = state_q;
        pass_sel = 1'b0;
        case (state_q)
            StIdle: begin
                pass_sel = !cfg_en || (s_axis_tdata[IdByte*8 +: 8] == cfg_id);
                // A single-word frame never leaves IDLE.
                if (in_fire && !s_axis_tlast) begin
                    state_d = pass_sel ? StPass : StDrop;
                end
            end
            StPass: begin
                pass_sel = 1'b1;
                if (last_fire) state_d = StIdle;
            end
            StDrop: begin
                if (last_fire) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Running checksum; restarts on each first word and excludes the trailer byte.
    always_comb begin
        csum_base = (state_q == StIdle) ? 8'h00 : csum_q;
        csum_calc = csum_base ^ xor_bytes(s_axis_tdata, 1'b1);
        fwd_user  = s_axis_tlast &
                    ((csum_calc != s_axis_tdata[CsumByte*8 +: 8]) | s_axis_tuser);
        csum_d    = csum_q;
        if (in_fire) begin
            csum_d = s_axis_tlast ? 8'h00 : (csum_base ^ xor_bytes(s_axis_tdata, 1'b0));
        end
    end

    assign pass_inc = last_fire & pass_sel;
    assign drop_inc = last_fire & !pass_sel;
    assign err_inc  = pass_inc & fwd_user;

    // FSM and checksum registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            csum_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            csum_q  <= csum_d;
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= '0;
            drop_q <= '0;
            err_q  <= '0;
        end else if (stat_clr) begin
            pass_q <= '0;
            drop_q <= '0;
            err_q  <= '0;
        end else begin
            if (pass_inc && !(&pass_q)) pass_q <= pass_q + CNT_W'(1);
            if (drop_inc && !(&drop_q)) drop_q <= drop_q + CNT_W'(1);
            if (err_inc  && !(&err_q))  err_q  <= err_q + CNT_W'(1);
        end
    end

    assign stat_pass = pass_q;
    assign stat_drop = drop_q;
    assign stat_err  = err_q;

    axis_skid_buf u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (s_axis_tdata),
        .in_last   (s_axis_tlast),
        .in_user   (fwd_user),
        .in_valid  (s_axis_tvalid & pass_sel),
        .in_ready  (s_axis_tready),
        .out_data  (m_axis_tdata),
        .out_last  (m_axis_tlast),
        .out_user  (m_axis_tuser),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

endmodule

// File: tb/tb_frame_filter.sv
// Directed testbench for frame_filter. Counters are built 3 bits wide so that
// saturation is reachable with a handful of frames.
module tb_frame_filter;

    localparam int unsigned CW = 3;

    logic          clk;
    logic          rst_n;
    logic [31:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tuser;
    logic          s_axis_tready;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          m_axis_tready;
    logic          cfg_en;
    logic [7:0]    cfg_id;
    logic          stat_clr;
    logic [CW-1:0] stat_pass;
    logic [CW-1:0] stat_drop;
    logic [CW-1:0] stat_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Output words as {user, last, data}.
    logic [33:0] got_q[$];
    logic [33:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    frame_filter #(
        .CNT_W (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .cfg_en        (cfg_en),
        .cfg_id        (cfg_id),
        .stat_clr      (stat_clr),
        .stat_pass     (stat_pass),
        .stat_drop     (stat_drop),
        .stat_err      (stat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture output transfers and verify data holds while stalled.
    always @(posedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", m_axis_tvalid, 1);
                check("hold_data", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
        prev_stall <= rst_n && m_axis_tvalid && !m_axis_tready;
        prev_data  <= m_axis_tdata;
    end

    // Present one word at a negedge and hold it until the edge that accepts it.
    task automatic send_word(input logic [31:0] d, input logic l, input logic u);
        int n;
        n = 0;
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) check("tready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (m_axis_tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (m_axis_tvalid) check("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic clear_stats();
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("clr_pass", stat_pass, 0);
        check("clr_drop", stat_drop, 0);
        check("clr_err", stat_err, 0);
    endtask

    task automatic expect_words(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_word"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b1;
        cfg_en        = 1'b1;
        cfg_id        = 8'h11;
        stat_clr      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tready", s_axis_tready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_pass", stat_pass, 0);
        check("rst_drop", stat_drop, 0);
        check("rst_err", stat_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_after_rst", s_axis_tready, 1);

        // Matching frame: bytes 11^11^33^22 give checksum 0x11, so 0x11 is a clean trailer.
        // cfg_id changes mid-frame and must not matter.
        send_word(32'h2233_1111, 1'b0, 1'b0);
        check("t1_lat_valid", m_axis_tvalid, 1);
        check("t1_lat_data", m_axis_tdata, 32'h2233_1111);
        check("t1_lat_user", m_axis_tuser, 0);
        cfg_id = 8'h55;
        send_word(32'h0000_0011, 1'b1, 1'b0);
        check("t1_last_data", m_axis_tdata, 32'h0000_0011);
        check("t1_last_tlast", m_axis_tlast, 1);
        check("t1_last_user", m_axis_tuser, 0);
        check("t1_pass", stat_pass, 1);
        check("t1_err", stat_err, 0);
        idle();
        wait_drain();
        exp_q.push_back({2'b00, 32'h2233_1111});
        exp_q.push_back({2'b01, 32'h0000_0011});
        expect_words("t1");
        clear_stats();

        // Bad trailer 0x12 -> tuser on last word and error counted.
        cfg_id = 8'h11;
        send_word(32'h2233_1111, 1'b0, 1'b0);
        send_word(32'h0000_0012, 1'b1, 1'b0);
        idle();
        wait_drain();
        check("t2_pass", stat_pass, 1);
        check("t2_err", stat_err, 1);
        exp_q.push_back({2'b00, 32'h2233_1111});
        exp_q.push_back({2'b11, 32'h0000_0012});
        expect_words("t2");
        clear_stats();

        // ID mismatch -> frame dropped, input keeps flowing.
        cfg_id = 8'h12;
        send_word(32'h2233_1111, 1'b0, 1'b0);
        check("t3_tready1", s_axis_tready, 1);
        check("t3_tvalid1", m_axis_tvalid, 0);
        send_word(32'h0000_0011, 1'b1, 1'b0);
        check("t3_tready2", s_axis_tready, 1);
        check("t3_tvalid2", m_axis_tvalid, 0);
        check("t3_drop", stat_drop, 1);
        check("t3_pass", stat_pass, 0);
        idle();
        wait_drain();
        expect_words("t3");
        clear_stats();

        // 5-word frame under a toggling downstream ready; bytes XOR to 0x00.
        cfg_id = 8'h11;
        fork
            begin
                send_word(32'h0403_0211, 1'b0, 1'b0);
                send_word(32'h0807_0605, 1'b0, 1'b0);
                send_word(32'h0C0B_0A09, 1'b0, 1'b0);
                send_word(32'h100F_0E0D, 1'b0, 1'b0);
                send_word(32'h0000_0000, 1'b1, 1'b0);
                idle();
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    m_axis_tready = ~m_axis_tready;
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_drain();
        check("t4_pass", stat_pass, 1);
        check("t4_err", stat_err, 0);
        exp_q.push_back({2'b00, 32'h0403_0211});
        exp_q.push_back({2'b00, 32'h0807_0605});
        exp_q.push_back({2'b00, 32'h0C0B_0A09});
        exp_q.push_back({2'b00, 32'h100F_0E0D});
        exp_q.push_back({2'b01, 32'h0000_0000});
        expect_words("t4");

        // Full stall: one word in the output register, one in the skid, then tready=0.
        m_axis_tready = 1'b0;
        send_word(32'h0000_AA11, 1'b0, 1'b0);
        send_word(32'h0000_BB00, 1'b0, 1'b0);
        check("stall_tready", s_axis_tready, 0);
        check("stall_data", m_axis_tdata, 32'h0000_AA11);
        m_axis_tready = 1'b1;
        send_word(32'h0000_0000, 1'b1, 1'b0);
        idle();
        wait_drain();
        exp_q.push_back({2'b00, 32'h0000_AA11});
        exp_q.push_back({2'b00, 32'h0000_BB00});
        exp_q.push_back({2'b01, 32'h0000_0000});
        expect_words("stall");
        clear_stats();

        // Single-word frame with filtering off: 55^AA^00 = 0xFF vs trailer 0x11 -> error.
        cfg_en = 1'b0;
        cfg_id = 8'h22;
        send_word(32'h00AA_5511, 1'b1, 1'b0);
        check("t5_valid", m_axis_tvalid, 1);
        check("t5_tlast", m_axis_tlast, 1);
        check("t5_user", m_axis_tuser, 1);
        check("t5_pass", stat_pass, 1);
        check("t5_err", stat_err, 1);
        idle();
        wait_drain();
        exp_q.push_back({2'b11, 32'h00AA_5511});
        expect_words("t5");

        // Upstream error flag alone forces tuser on a frame with a good checksum.
        cfg_en = 1'b1;
        cfg_id = 8'h11;
        send_word(32'h2233_1111, 1'b0, 1'b0);
        send_word(32'h0000_0011, 1'b1, 1'b1);
        check("tuser_in_user", m_axis_tuser, 1);
        check("tuser_in_err", stat_err, 2);
        idle();
        wait_drain();
        got_q.delete();

        // Clear in the same cycle as a counted frame wins.
        clear_stats();
        stat_clr = 1'b1;
        send_word(32'h0000_0011, 1'b1, 1'b0);
        stat_clr = 1'b0;
        check("clr_prio_pass", stat_pass, 0);
        check("clr_prio_err", stat_err, 0);
        idle();
        wait_drain();
        got_q.delete();

        // Saturation: nine dropped single-word frames on a 3-bit counter stop at 7.
        for (int i = 0; i < 9; i++) begin
            send_word(32'h0000_0077, 1'b1, 1'b0);
            check("sat_drop", stat_drop, (i < 7) ? (i + 1) : 7);
        end
        idle();

        // Reset mid-frame with words buffered, then a clean frame.
        send_word(32'h0000_0011, 1'b1, 1'b0);
        idle();
        wait_drain();
        got_q.delete();
        m_axis_tready = 1'b0;
        send_word(32'h0403_0211, 1'b0, 1'b0);
        send_word(32'h0807_0605, 1'b0, 1'b0);
        @(negedge clk);
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_tready", s_axis_tready, 0);
        check("mid_rst_pass", stat_pass, 0);
        check("mid_rst_drop", stat_drop, 0);
        m_axis_tready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_tready_up", s_axis_tready, 1);
        send_word(32'h2233_1111, 1'b0, 1'b0);
        send_word(32'h0000_0011, 1'b1, 1'b0);
        check("mid_rst_pass_after", stat_pass, 1);
        idle();
        wait_drain();
        exp_q.push_back({2'b00, 32'h2233_1111});
        exp_q.push_back({2'b01, 32'h0000_0011});
        expect_words("mid_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
